visualizador_resultado: RTL and testbench

Display stage directly downstream of the operations unit. On a load strobe it captures the 6-bit `resultado_operacion` and both warning outputs (`salidawar1`, `salidawar2`), and converts the result to two BCD digits with a sequential double-dabble. It then drives a 4-digit, multiplexed, common-anode 7-segment display so the operator sees the result and warning status on the board.

---
 rtl/visualizador_pkg.sv | 46 ++++
 rtl/conversor_bcd.sv | 61 ++++++
 rtl/visualizador_resultado.sv | 168 ++++++++++++++++
 tb/tb_visualizador_resultado.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/visualizador_pkg.sv
// Shared definitions for the result display: FSM encoding, 7-segment patterns
// (active-low, {a,b,c,d,e,f,g}) and the double-dabble step count.
package visualizador_pkg;

    typedef enum logic [1:0] {
        REPOSO,
        CONVERSION,
        ACTUALIZAR
    } estado_t;

    // One double-dabble step per result bit.
    localparam int unsigned PASOS_DD = 6;

    localparam logic [6:0] SEG_0      = 7'b0000001;
    localparam logic [6:0] SEG_1      = 7'b1001111;
    localparam logic [6:0] SEG_2      = 7'b0010010;
    localparam logic [6:0] SEG_3      = 7'b0000110;
    localparam logic [6:0] SEG_4      = 7'b1001100;
    localparam logic [6:0] SEG_5      = 7'b0100100;
    localparam logic [6:0] SEG_6      = 7'b0100000;
    localparam logic [6:0] SEG_7      = 7'b0001111;
    localparam logic [6:0] SEG_8      = 7'b0000000;
    localparam logic [6:0] SEG_9      = 7'b0000100;
    localparam logic [6:0] SEG_E      = 7'b0110000;
    localparam logic [6:0] SEG_BLANCO = 7'b1111111;

    // Decimal digit to segment pattern; non-decimal codes are shown blank.
    function automatic logic [6:0] seg_digito(input logic [3:0] valor);
        logic [6:0] patron;
        case (valor)
            4'd0:    patron = SEG_0;
            4'd1:    patron = SEG_1;
            4'd2:    patron = SEG_2;
            4'd3:    patron = SEG_3;
            4'd4:    patron = SEG_4;
            4'd5:    patron = SEG_5;
            4'd6:    patron = SEG_6;
            4'd7:    patron = SEG_7;
            4'd8:    patron = SEG_8;
            4'd9:    patron = SEG_9;
            default: patron = SEG_BLANCO;
        endcase
        return patron;
    endfunction

endpackage

// File: rtl/conversor_bcd.sv
// Sequential 6-bit binary to two-digit BCD converter (double-dabble, MSB first,
// one step per clock). listo flags the cycle in which the final step executes,
// so unidades/decenas hold the finished result from the following cycle on.
module conversor_bcd
    import visualizador_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [5:0] dato,
    output logic [3:0] unidades,
    output logic [3:0] decenas,
    output logic       listo
);

    logic [5:0] r_desp;
    logic [7:0] r_bcd;
    logic [2:0] r_paso;
    logic       r_activo;
    logic [7:0] w_bcd_ajuste;
    logic       w_ultimo;

    // Add-3 correction on each nibble before it is doubled by the shift.
    always_comb begin
        w_bcd_ajuste = r_bcd;
        if (r_bcd[3:0] >= 4'd5) begin
            w_bcd_ajuste[3:0] = r_bcd[3:0] + 4'd3;
        end
        if (r_bcd[7:4] >= 4'd5) begin
            w_bcd_ajuste[7:4] = r_bcd[7:4] + 4'd3;
        end
    end

    assign w_ultimo = (r_paso == 3'(PASOS_DD - 1));

    // Load on iniciar, then shift the corrected BCD/binary pair left once per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_desp   <= '0;
            r_bcd    <= '0;
            r_paso   <= '0;
            r_activo <= 1'b0;
        end else if (iniciar) begin
            r_desp   <= dato;
            r_bcd    <= '0;
            r_paso   <= '0;
            r_activo <= 1'b1;
        end else if (r_activo) begin
            {r_bcd, r_desp} <= {w_bcd_ajuste[6:0], r_desp, 1'b0};
            r_paso          <= r_paso + 3'd1;
            if (w_ultimo) begin
                r_activo <= 1'b0;
            end
        end
    end

    assign unidades = r_bcd[3:0];
    assign decenas  = r_bcd[7:4];
    assign listo    = r_activo && w_ultimo;

endmodule

// File: rtl/visualizador_resultado.sv
// Result display stage: captures result and warnings on cargar, converts the
// result to BCD, and scans a 4-digit common-anode 7-segment display.
module visualizador_resultado
    import visualizador_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] resultado_operacion,
    input  logic       salidawar1,
    input  logic [2:0] salidawar2,
    input  logic       cargar,
    output logic       ocupado,
    output logic [3:0] anodos,
    output logic [6:0] segmentos
);

    localparam int unsigned ANCHO_CNT = $clog2(REFRESH_DIV);
    localparam logic [ANCHO_CNT-1:0] CNT_MAX = ANCHO_CNT'(REFRESH_DIV - 1);

    estado_t r_estado, w_estado_d;
    logic    w_iniciar, w_actualizar, w_listo;

    logic [3:0] w_unidades, w_decenas;
    logic       r_war1_lat;
    logic [2:0] r_war2_lat;

    logic [3:0] r_unidades, r_decenas;
    logic [2:0] r_codigo;
    logic       r_error;

    logic [ANCHO_CNT-1:0] r_cuenta;
    logic [1:0]           r_indice, w_indice_d;
    logic                 w_fin_cuenta;

    logic [3:0] r_anodos, w_anodos_d;
    logic [6:0] r_segmentos, w_segmentos_d;

    conversor_bcd u_conversor (
        .clk      (clk),
        .reset    (reset),
        .iniciar  (w_iniciar),
        .dato     (resultado_operacion),
        .unidades (w_unidades),
        .decenas  (w_decenas),
        .listo    (w_listo)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_estado <= REPOSO;
        end else begin
            r_estado <= w_estado_d;
        end
    end

    // Next-state logic; cargar only matters in REPOSO.
    always_comb begin
        w_estado_d   = r_estado;
        w_iniciar    = 1'b0;
        w_actualizar = 1'b0;
        unique case (r_estado)
            REPOSO: begin
                if (cargar) begin
                    w_iniciar  = 1'b1;
                    w_estado_d = CONVERSION;
                end
            end
            CONVERSION: begin
                if (w_listo) begin
                    w_estado_d = ACTUALIZAR;
                end
            end
            ACTUALIZAR: begin
                w_actualizar = 1'b1;
                w_estado_d   = REPOSO;
            end
            default: w_estado_d = REPOSO;
        endcase
    end

    assign ocupado = (r_estado != REPOSO);

    // Warnings are latched at capture so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_war1_lat <= 1'b0;
            r_war2_lat <= '0;
        end else if (w_iniciar) begin
            r_war1_lat <= salidawar1;
            r_war2_lat <= salidawar2;
        end
    end

    // Display registers change only once a conversion has fully completed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_unidades <= '0;
            r_decenas  <= '0;
            r_codigo   <= '0;
            r_error    <= 1'b0;
        end else if (w_actualizar) begin
            r_unidades <= w_unidades;
            r_decenas  <= w_decenas;
            r_codigo   <= r_war2_lat;
            r_error    <= r_war1_lat;
        end
    end

    assign w_fin_cuenta = (r_cuenta == CNT_MAX);
    assign w_indice_d   = w_fin_cuenta ? r_indice + 2'd1 : r_indice;

    // Free-running refresh counter and digit index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cuenta <= '0;
            r_indice <= '0;
        end else begin
            r_cuenta <= w_fin_cuenta ? '0 : r_cuenta + 1'b1;
            r_indice <= w_indice_d;
        end
    end

    // Digit select and segment mux, evaluated for the index of the next cycle.
    always_comb begin
        w_anodos_d    = 4'b1111;
        w_segmentos_d = SEG_BLANCO;
        unique case (w_indice_d)
            2'd0: begin
                w_anodos_d    = 4'b1110;
                w_segmentos_d = seg_digito(r_unidades);
            end
            2'd1: begin
                w_anodos_d    = 4'b1101;
                w_segmentos_d = seg_digito(r_decenas);
            end
            2'd2: begin
                w_anodos_d    = 4'b1011;
                w_segmentos_d = seg_digito({1'b0, r_codigo});
            end
            2'd3: begin
                w_anodos_d    = 4'b0111;
                w_segmentos_d = r_error ? SEG_E : SEG_BLANCO;
            end
            default: begin
                w_anodos_d    = 4'b1111;
                w_segmentos_d = SEG_BLANCO;
            end
        endcase
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_anodos    <= 4'b1110;
            r_segmentos <= SEG_0;
        end else begin
            r_anodos    <= w_anodos_d;
            r_segmentos <= w_segmentos_d;
        end
    end

    assign anodos    = r_anodos;
    assign segmentos = r_segmentos;

endmodule

// File: tb/tb_visualizador_resultado.sv
// Scoreboard bench for visualizador_resultado with a short refresh period.
module tb_visualizador_resultado;

    localparam int unsigned DIV = 4;
    localparam int unsigned LIMITE_DIGITO = 4 * DIV + 4;

    logic       clk;
    logic       reset;
    logic [5:0] resultado_operacion;
    logic       salidawar1;
    logic [2:0] salidawar2;
    logic       cargar;
    logic       ocupado;
    logic [3:0] anodos;
    logic [6:0] segmentos;

    typedef struct packed {
        logic [6:0] d0;
        logic [6:0] d1;
        logic [6:0] d2;
        logic [6:0] d3;
    } pantalla_t;

    pantalla_t sb[$];
    int        n_total = 0;
    int        n_ok    = 0;

    logic [6:0] tabla_seg [0:9];
    logic [6:0] seg_e;
    logic [6:0] seg_blanco;

    visualizador_resultado #(
        .REFRESH_DIV (DIV)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .resultado_operacion (resultado_operacion),
        .salidawar1          (salidawar1),
        .salidawar2          (salidawar2),
        .cargar              (cargar),
        .ocupado             (ocupado),
        .anodos              (anodos),
        .segmentos           (segmentos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_total++;
        if (obs === esp) begin
            n_ok++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, esp);
        end
    endtask

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    function automatic pantalla_t esperado(input int valor, input bit w1, input int w2);
        pantalla_t p;
        p.d0 = tabla_seg[valor % 10];
        p.d1 = tabla_seg[valor / 10];
        p.d2 = tabla_seg[w2];
        p.d3 = w1 ? seg_e : seg_blanco;
        return p;
    endfunction

    // Pulse cargar for one edge, then scramble the inputs after the capture edge.
    task automatic cargar_pulso(input int valor, input bit w1, input int w2, input bit aceptada);
        resultado_operacion = 6'(valor);
        salidawar1          = w1;
        salidawar2          = 3'(w2);
        cargar              = 1'b1;
        paso();
        cargar              = 1'b0;
        resultado_operacion = ~6'(valor);
        salidawar1          = ~w1;
        salidawar2          = ~3'(w2);
        if (aceptada) sb.push_back(esperado(valor, w1, w2));
    endtask

    task automatic medir_ocupado(output int n);
        n = 0;
        while (ocupado === 1'b1 && n < 20) begin
            paso();
            n++;
        end
    endtask

    task automatic leer_digito(input int i, input string tag, input logic [6:0] esp);
        logic [3:0] objetivo;
        int         n;
        objetivo = ~(4'b0001 << i);
        n = 0;
        while (anodos !== objetivo && n < LIMITE_DIGITO) begin
            paso();
            n++;
        end
        if (n >= LIMITE_DIGITO) comprobar({tag, " anodo"}, 32'(anodos), 32'(objetivo));
        comprobar(tag, 32'(segmentos), 32'(esp));
    endtask

    task automatic verificar_pantalla(input string tag);
        pantalla_t e;
        comprobar({tag, " cola"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            leer_digito(0, {tag, " dig0"}, e.d0);
            leer_digito(1, {tag, " dig1"}, e.d1);
            leer_digito(2, {tag, " dig2"}, e.d2);
            leer_digito(3, {tag, " dig3"}, e.d3);
        end
    endtask

    initial begin
        int n;
        int carga_val [3] = '{50, 59, 18};
        int carga_w1  [3] = '{0, 0, 1};
        int carga_w2  [3] = '{5, 7, 2};
        logic [3:0] orden [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        tabla_seg[0] = 7'b0000001; tabla_seg[1] = 7'b1001111;
        tabla_seg[2] = 7'b0010010; tabla_seg[3] = 7'b0000110;
        tabla_seg[4] = 7'b1001100; tabla_seg[5] = 7'b0100100;
        tabla_seg[6] = 7'b0100000; tabla_seg[7] = 7'b0001111;
        tabla_seg[8] = 7'b0000000; tabla_seg[9] = 7'b0000100;
        seg_e        = 7'b0110000;
        seg_blanco   = 7'b1111111;

        reset               = 1'b0;
        cargar              = 1'b0;
        resultado_operacion = '0;
        salidawar1          = 1'b0;
        salidawar2          = '0;

        // Reset state and first dwell.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        comprobar("rst ocupado", 32'(ocupado), 0);
        comprobar("rst anodos", 32'(anodos), 32'b1110);
        comprobar("rst segmentos", 32'(segmentos), 32'b0000001);
        repeat (3) paso();
        comprobar("rst dwell", 32'(anodos), 32'b1110);
        paso();
        comprobar("rst anodos tras 4", 32'(anodos), 32'b1101);

        // Load 45: busy length and digits.
        cargar_pulso(45, 1'b0, 0, 1'b1);
        medir_ocupado(n);
        comprobar("45 ocupado ciclos", n, 7);
        paso();
        verificar_pantalla("45");

        // Load 63 with warnings; cargar held across edges N+6 and N+7 is ignored.
        cargar_pulso(63, 1'b1, 3, 1'b1);
        repeat (5) paso();
        resultado_operacion = 6'd20;
        cargar              = 1'b1;
        paso();
        paso();
        cargar = 1'b0;
        comprobar("63 carga en ACTUALIZAR ignorada", 32'(ocupado), 0);
        paso();
        comprobar("63 sigue libre", 32'(ocupado), 0);
        verificar_pantalla("63");

        // Load 12, second load three cycles later is dropped.
        cargar_pulso(12, 1'b0, 4, 1'b1);
        repeat (2) paso();
        cargar_pulso(50, 1'b1, 6, 1'b0);
        medir_ocupado(n);
        comprobar("12 ocupado ciclos", n, 4);
        paso();
        verificar_pantalla("12");

        // Loads after busy drops, from a table.
        for (int k = 0; k < 3; k++) begin
            cargar_pulso(carga_val[k], carga_w1[k] != 0, carga_w2[k], 1'b1);
            medir_ocupado(n);
            comprobar("tabla ocupado ciclos", n, 7);
            paso();
            verificar_pantalla($sformatf("carga %0d", carga_val[k]));
        end

        // Earliest next load is accepted at N+8, right after busy drops.
        cargar_pulso(27, 1'b0, 1, 1'b0);
        medir_ocupado(n);
        cargar_pulso(36, 1'b1, 0, 1'b1);
        comprobar("N+8 aceptada", 32'(ocupado), 1);
        medir_ocupado(n);
        comprobar("N+8 ocupado ciclos", n, 7);
        paso();
        verificar_pantalla("36");

        // Reset during a conversion: nothing of the aborted load survives.
        cargar_pulso(63, 1'b1, 7, 1'b0);
        repeat (2) paso();
        reset = 1'b0;
        repeat (2) paso();
        reset = 1'b1;
        comprobar("abort ocupado", 32'(ocupado), 0);
        repeat (8) paso();
        comprobar("abort ocupado tarde", 32'(ocupado), 0);
        sb.push_back(esperado(0, 1'b0, 0));
        verificar_pantalla("abort");

        // Refresh order and dwell.
        n = 0;
        while (anodos === 4'b1110 && n < LIMITE_DIGITO) begin
            paso();
            n++;
        end
        n = 0;
        while (anodos !== 4'b1110 && n < LIMITE_DIGITO) begin
            paso();
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            comprobar($sformatf("orden %0d", k), 32'(anodos), 32'(orden[k]));
            n = 0;
            while (anodos === orden[k] && n < 20) begin
                paso();
                n++;
            end
            comprobar($sformatf("dwell %0d", k), n, DIV);
        end
        comprobar("orden vuelta", 32'(anodos), 32'b1110);

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
